// File: rtl/approx_mul_err_engine.sv
// approx_mul_err_engine
//   Sweeps every ordered pair (i, j) of the first n_ops operand-table entries
//   through an external signed approximate multiplier, compares each returned
//   product with the exact signed product and accumulates error statistics.
//
// Ports
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   ld_en/addr/data     operand table write port (ignored while busy)
//   n_ops, start        run size (1..DEPTH) and one-cycle run request
//   mul_a, mul_b        registered operands to the external multiplier
//   approx_p            multiplier result, DUT_LAT cycles after mul_a/mul_b
//   busy, done          run in progress / one-cycle completion pulse
//   pair_cnt, err_cnt   pairs accumulated / pairs with a nonzero error
//   sum_abs_err         sum of |approx_p - exact|
//   sum_err             signed sum of (approx_p - exact)
//   max_abs_err         largest |approx_p - exact|
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a valid start; statistics hold
// S_ISSUE | one pair per cycle into the multiplier and alignment pipe
// S_DRAIN | waiting for the last token to be accumulated, then done
module approx_mul_err_engine #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10,
   parameter int DUT_LAT = 0,
   parameter int ACC_W   = 2*WIDTH + 2*ADDR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld_en,
   input  logic [ADDR_W-1:0]     ld_addr,
   input  logic [WIDTH-1:0]      ld_data,
   input  logic [ADDR_W:0]       n_ops,
   input  logic                  start,
   output logic [WIDTH-1:0]      mul_a,
   output logic [WIDTH-1:0]      mul_b,
   input  logic [2*WIDTH-1:0]    approx_p,
   output logic                  busy,
   output logic                  done,
   output logic [2*ADDR_W+1:0]   pair_cnt,
   output logic [2*ADDR_W+1:0]   err_cnt,
   output logic [ACC_W-1:0]      sum_abs_err,
   output logic [ACC_W-1:0]      sum_err,
   output logic [2*WIDTH:0]      max_abs_err
);

   localparam int PW = 2*WIDTH;
   localparam int CW = 2*ADDR_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t               state;
   logic [WIDTH-1:0]     tbl [DEPTH];
   logic [ADDR_W-1:0]    idx_i, idx_j;
   logic [ADDR_W:0]      n_lat;
   logic                 iss_v, acc_v;
   logic                 start_ok, j_last, i_last;
   logic signed [PW-1:0] exact_c;
   logic                 out_v, pipe_busy;
   logic [PW-1:0]        out_e;
   logic signed [PW:0]   diff;
   logic [PW:0]          abs_diff;

   assign start_ok = start && (n_ops != '0) && (n_ops <= (ADDR_W+1)'(DEPTH));
   assign j_last   = ({1'b0, idx_j} == n_lat - (ADDR_W+1)'(1));
   assign i_last   = ({1'b0, idx_i} == n_lat - (ADDR_W+1)'(1));

   // Busy is low in the start cycle, so a same-cycle write lands before the first read.
   always_ff @(posedge clk) begin
      if (ld_en && !busy && ({1'b0, ld_addr} < (ADDR_W+1)'(DEPTH)))
         tbl[ld_addr] <= ld_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         mul_a <= '0;
         mul_b <= '0;
         iss_v <= 1'b0;
         idx_i <= '0;
         idx_j <= '0;
         n_lat <= '0;
      end else begin
         done  <= 1'b0;
         iss_v <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  n_lat <= n_ops;
                  idx_i <= '0;
                  idx_j <= '0;
                  busy  <= 1'b1;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mul_a <= tbl[idx_i];
               mul_b <= tbl[idx_j];
               iss_v <= 1'b1;
               if (j_last) begin
                  idx_j <= '0;
                  if (i_last) state <= S_DRAIN;
                  else        idx_i <= idx_i + ADDR_W'(1);
               end else begin
                  idx_j <= idx_j + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               // acc_v keeps done behind the final statistics update.
               if (!pipe_busy && !acc_v) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign exact_c = $signed(mul_a) * $signed(mul_b);

   // Exact product and valid travel alongside the external multiplier.
   generate
      if (DUT_LAT == 0) begin : g_nopipe
         assign out_v     = iss_v;
         assign out_e     = exact_c;
         assign pipe_busy = iss_v;
      end else begin : g_pipe
         logic [DUT_LAT-1:0] pv;
         logic [PW-1:0]      pe [DUT_LAT];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pv <= '0;
            end else begin
               pv[0] <= iss_v;
               for (int k = 1; k < DUT_LAT; k++) pv[k] <= pv[k-1];
            end
         end

         always_ff @(posedge clk) begin
            pe[0] <= exact_c;
            for (int k = 1; k < DUT_LAT; k++) pe[k] <= pe[k-1];
         end

         assign out_v     = pv[DUT_LAT-1];
         assign out_e     = pe[DUT_LAT-1];
         assign pipe_busy = iss_v | (|pv);
      end
   endgenerate

   // One extra bit so that the most negative difference still has a magnitude.
   assign diff     = $signed({approx_p[PW-1], approx_p}) - $signed({out_e[PW-1], out_e});
   assign abs_diff = diff[PW] ? (PW+1)'(-diff) : (PW+1)'(diff);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_v       <= 1'b0;
         pair_cnt    <= '0;
         err_cnt     <= '0;
         sum_abs_err <= '0;
         sum_err     <= '0;
         max_abs_err <= '0;
      end else begin
         acc_v <= out_v;
         if (state == S_IDLE && start_ok) begin
            pair_cnt    <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_err     <= '0;
            max_abs_err <= '0;
         end else if (out_v) begin
            pair_cnt    <= pair_cnt + CW'(1);
            if (diff != '0) err_cnt <= err_cnt + CW'(1);
            sum_abs_err <= sum_abs_err + ACC_W'(abs_diff);
            sum_err     <= sum_err + ACC_W'(diff);
            if (abs_diff > max_abs_err) max_abs_err <= abs_diff;
         end
      end
   end

endmodule

// File: doc/approx_mul_err_engine.md
Name: approx_mul_err_engine

Overview:
- On-chip, parametrised evaluation engine for signed approximate multipliers.
- Holds an operand table and sweeps every ordered pair (i, j) of the first n_ops entries through an external approximate multiplier.
- Compares each returned product against an internally computed exact signed product and accumulates error statistics.
- Replaces file-based offline comparison with a self-contained, cycle-accurate run usable in simulation or on FPGA.

Parameters:
- WIDTH, 32, operand width in bits (signed two's complement).
- DEPTH, 1024, operand table entries.
- ADDR_W, 10, table address width; DEPTH <= 2**ADDR_W.
- DUT_LAT, 0, pipeline latency of the external multiplier in cycles (0 = combinational).
- ACC_W, 2*WIDTH+2*ADDR_W+1, accumulator width; never overflows for a full DEPTH*DEPTH sweep.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- ld_en  in  1  operand table write strobe.
- ld_addr  in  ADDR_W  table write address.
- ld_data  in  WIDTH  table write data.
- n_ops  in  ADDR_W+1  entries to sweep, 1..DEPTH; sampled on start.
- start  in  1  one-cycle run request.
- mul_a  out  WIDTH  operand A to the multiplier (table[i]).
- mul_b  out  WIDTH  operand B to the multiplier (table[j]).
- approx_p  in  2*WIDTH  multiplier result, valid DUT_LAT cycles after mul_a/mul_b.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the last result is accumulated.
- pair_cnt  out  2*ADDR_W+2  pairs accumulated.
- err_cnt  out  2*ADDR_W+2  pairs with approx_p != exact.
- sum_abs_err  out  ACC_W  sum of |approx_p - exact|.
- sum_err  out  ACC_W  signed sum of (approx_p - exact), i.e. bias.
- max_abs_err  out  2*WIDTH+1  largest |approx_p - exact|.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - busy=0, done=0; mul_a=0, mul_b=0.
  - All statistics are zero and the pipeline valids are cleared.
  - Table contents are not reset.
- FSM IDLE:
  - start=1 → clears all statistics, latches n_ops, sets i=0, j=0, enters ISSUE.
  - busy goes to 1 the cycle after start.
  - start with n_ops=0 or n_ops>DEPTH is ignored and the FSM stays in IDLE.
- FSM ISSUE:
  - Each cycle drives mul_a=table[i], mul_b=table[j] and a valid token into a DUT_LAT-deep alignment pipe.
  - The pipe carries the exact product and the valid bit.
  - j increments each cycle; on j=n_ops-1, j wraps to 0 and i increments.
  - After issuing pair (n_ops-1, n_ops-1), the FSM enters DRAIN.
  - Exactly n_ops² pairs are issued, one per cycle, with no bubbles.
- FSM DRAIN:
  - Waits until the alignment pipe holds no valid token.
  - Then pulses done for one cycle and returns to IDLE with busy=0.
  - Statistics hold until the next accepted start.
- Operand registers:
  - mul_a/mul_b are registered from a synchronous table read.
  - Table read address issue precedes operand presentation by one cycle; the exact product is aligned accordingly.
- Arithmetic:
  - exact = signed(table[i]) * signed(table[j]), 2*WIDTH bits.
  - diff = sext(approx_p) - sext(exact), 2*WIDTH+1 bits.
  - abs(diff) is computed at 2*WIDTH+1 bits, so -2^(2W) is representable.
  - sum_err is sign-extended to ACC_W.
- Accumulation:
  - One result per cycle, registered.
  - Statistics reflect a result one cycle after it exits the alignment pipe.
  - max_abs_err updates only on strictly greater.
- Latency: total run length is n_ops² + DUT_LAT + 3 cycles from accepted start to the done pulse (fixed, checkable).
- start while busy is ignored.
- ld_en:
  - Writes when not busy.
  - Ignored while busy, so the table stays stable mid-run.
  - Write and start in the same cycle: the write commits; the run sees the new value.
- Reset mid-run: immediate return to IDLE. The pipe is flushed, statistics are zeroed, and no done pulse is issued.
- mul_a/mul_b hold their last value in IDLE/DRAIN; the approx_p input is ignored when no valid token is present.

Test Plan:
- Exact DUT (approx_p = mul_a*mul_b):
  - Stimulus: DUT_LAT=0, table {3, -5, 7}, n_ops=3.
  - Required: pair_cnt=9, err_cnt=0, sum_abs_err=0, max_abs_err=0; done exactly 12 cycles after start.
- Offset DUT (approx_p = exact+1) on the same table:
  - Required: err_cnt=9, sum_abs_err=9, sum_err=+9, max_abs_err=1.
- Extremes, WIDTH=32:
  - Stimulus: table {0x80000000}, n_ops=1, DUT returns 0.
  - Required: exact=2^62, err_cnt=1, sum_err=-2^62, max_abs_err=2^62.
- Latency alignment:
  - Stimulus: DUT_LAT=3 with a 3-stage registered exact DUT, n_ops=4.
  - Required: err_cnt=0, pair_cnt=16, done 22 cycles after start.
- Control robustness:
  - Stimulus: start and ld_en pulsed mid-run.
  - Required: both are ignored; the table read back afterwards is unchanged and statistics match the clean run.
- Reset mid-run:
  - Stimulus: rst_n=0 for 1 cycle at pair 5.
  - Required: busy=0, all statistics 0, no done pulse; a subsequent start completes normally.
